// File: rtl/haar_inv_lift.sv
// Inverse integer Haar lifting stage: rebuilds (x0, x1) from (approximation, detail)
// through a two-stage pipeline and tags each output pair with its row/frame position.
module haar_inv_lift #(
  parameter int DATA_W    = 16,
  parameter int ROW_PAIRS = 128,
  parameter int ROWS      = 128
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  start,
  input  logic [DATA_W-1:0]                                     dxy_approx,
  input  logic [DATA_W-1:0]                                     dxy_detail,
  output logic [DATA_W-1:0]                                     im11,
  output logic [DATA_W-1:0]                                     im21,
  output logic                                                  data_occur,
  output logic [((ROW_PAIRS > 1) ? $clog2(ROW_PAIRS) : 1)-1:0]  pair_cnt,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0]            row_cnt,
  output logic                                                  row_end,
  output logic                                                  frame_end
);

  localparam int PW = (ROW_PAIRS > 1) ? $clog2(ROW_PAIRS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [PW-1:0] LAST_PAIR = PW'(ROW_PAIRS - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);

  logic signed [DATA_W-1:0] half_d_s;
  logic [DATA_W-1:0]        x0_s;
  logic                     nxt_pair_last_s;
  logic                     nxt_row_last_s;

  logic [DATA_W-1:0]        s1_x0_r;
  logic [DATA_W-1:0]        s1_d_r;
  logic                     s1_v_r;
  // Position the next output pair will carry; the visible counters lag by one pair.
  logic [PW-1:0]            nxt_pair_r;
  logic [RW-1:0]            nxt_row_r;

  // Undo the update step (x0 = a - (d >>> 1)) and decode the wrap points of the tag counters.
  always_comb begin
    half_d_s        = $signed(dxy_detail) >>> 1;
    x0_s            = dxy_approx - half_d_s;
    nxt_pair_last_s = (nxt_pair_r == LAST_PAIR);
    nxt_row_last_s  = (nxt_row_r == LAST_ROW);
  end

  // Stage 1: capture x0 and d on start; data holds while the pipe is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_r  <= 1'b0;
      s1_x0_r <= {DATA_W{1'b0}};
      s1_d_r  <= {DATA_W{1'b0}};
    end else begin
      s1_v_r <= start;
      if (start) begin
        s1_x0_r <= x0_s;
        s1_d_r  <= dxy_detail;
      end else begin
        s1_x0_r <= s1_x0_r;
        s1_d_r  <= s1_d_r;
      end
    end
  end

  // Stage 2: rebuild x1, register outputs with their position tags and advance the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      im11       <= {DATA_W{1'b0}};
      im21       <= {DATA_W{1'b0}};
      data_occur <= 1'b0;
      pair_cnt   <= {PW{1'b0}};
      row_cnt    <= {RW{1'b0}};
      row_end    <= 1'b0;
      frame_end  <= 1'b0;
      nxt_pair_r <= {PW{1'b0}};
      nxt_row_r  <= {RW{1'b0}};
    end else if (s1_v_r) begin
      im11       <= s1_x0_r;
      im21       <= s1_x0_r + s1_d_r;
      data_occur <= 1'b1;
      pair_cnt   <= nxt_pair_r;
      row_cnt    <= nxt_row_r;
      row_end    <= nxt_pair_last_s;
      frame_end  <= nxt_pair_last_s & nxt_row_last_s;
      if (nxt_pair_last_s) begin
        nxt_pair_r <= {PW{1'b0}};
        if (nxt_row_last_s) begin
          nxt_row_r <= {RW{1'b0}};
        end else begin
          nxt_row_r <= nxt_row_r + 1'b1;
        end
      end else begin
        nxt_pair_r <= nxt_pair_r + 1'b1;
        nxt_row_r  <= nxt_row_r;
      end
    end else begin
      im11       <= im11;
      im21       <= im21;
      data_occur <= 1'b0;
      pair_cnt   <= pair_cnt;
      row_cnt    <= row_cnt;
      row_end    <= 1'b0;
      frame_end  <= 1'b0;
      nxt_pair_r <= nxt_pair_r;
      nxt_row_r  <= nxt_row_r;
    end
  end

endmodule

// File: tb/tb_haar_inv_lift.sv
// Scoreboard bench for haar_inv_lift: samples go through a forward Haar model, the
// coefficients drive the DUT, and a monitor checks reconstructed samples, tags and latency.
module tb_haar_inv_lift;

  localparam int DW = 16;
  localparam int RP = 4;
  localparam int RR = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] dxy_approx = '0;
  logic [DW-1:0] dxy_detail = '0;
  logic [DW-1:0] im11, im21;
  logic          data_occur;
  logic [1:0]    pair_cnt;
  logic [0:0]    row_cnt;
  logic          row_end, frame_end;

  haar_inv_lift #(.DATA_W(DW), .ROW_PAIRS(RP), .ROWS(RR)) dut (
    .clk(clk), .reset(reset), .start(start),
    .dxy_approx(dxy_approx), .dxy_detail(dxy_detail),
    .im11(im11), .im21(im21), .data_occur(data_occur),
    .pair_cnt(pair_cnt), .row_cnt(row_cnt),
    .row_end(row_end), .frame_end(frame_end)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] x0;
    logic [DW-1:0] x1;
    int            pair;
    int            row;
    bit            re;
    bit            fe;
    int            due;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [DW-1:0] last_x0 = '0;
  logic [DW-1:0] last_x1 = '0;
  int            n_pass = 0;
  int            n_total = 0;
  int            idx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Forward Haar lift as haar_lift defines it.
  task automatic fwd(input logic [DW-1:0] x0, input logic [DW-1:0] x1,
                     output logic [DW-1:0] a, output logic [DW-1:0] d);
    logic signed [DW-1:0] ds;
    logic signed [DW-1:0] half;
    ds   = x1 - x0;
    half = ds >>> 1;
    d    = ds;
    a    = x0 + half;
  endtask

  // One input cycle; a valid pair pushes its expected output tagged by its stream position.
  task automatic drive(input bit s, input logic [DW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] x0, input logic [DW-1:0] x1);
    exp_t e;
    @(posedge clk); #1;
    start = s; dxy_approx = a; dxy_detail = d;
    if (s) begin
      e.x0 = x0; e.x1 = x1;
      e.pair = idx % RP;
      e.row  = (idx / RP) % RR;
      e.re   = (e.pair == RP - 1);
      e.fe   = e.re && (e.row == RR - 1);
      e.due  = cyc + 2;
      exp_q.push_back(e);
      idx++;
    end
  endtask

  task automatic drive_samples(input logic [DW-1:0] x0, input logic [DW-1:0] x1);
    logic [DW-1:0] a, d;
    fwd(x0, x1, a, d);
    drive(1'b1, a, d, x0, x1);
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, '0);
  endtask

  function automatic logic [DW-1:0] pick();
    logic [DW-1:0] v;
    case ($urandom_range(0, 7))
      0: v = 16'h0000;
      1: v = 16'h7FFF;
      2: v = 16'h8000;
      3: v = 16'hFFFF;
      default: v = DW'($urandom);
    endcase
    return v;
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_im11"}, 32'(im11), 32'h0);
    chk({tag, "_im21"}, 32'(im21), 32'h0);
    chk({tag, "_data_occur"}, 32'(data_occur), 32'h0);
    chk({tag, "_pair_cnt"}, 32'(pair_cnt), 32'h0);
    chk({tag, "_row_cnt"}, 32'(row_cnt), 32'h0);
    chk({tag, "_row_end"}, 32'(row_end), 32'h0);
    chk({tag, "_frame_end"}, 32'(frame_end), 32'h0);
  endtask

  // Monitor: pops the scoreboard on every valid output; idle cycles must hold data and clear flags.
  always @(negedge clk) begin
    if (data_occur) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: im11=0x%0h im21=0x%0h with empty scoreboard", im11, im21);
      end else begin
        mon_e = exp_q.pop_front();
        chk("im11", 32'(im11), 32'(mon_e.x0));
        chk("im21", 32'(im21), 32'(mon_e.x1));
        chk("pair_cnt", 32'(pair_cnt), 32'(mon_e.pair));
        chk("row_cnt", 32'(row_cnt), 32'(mon_e.row));
        chk("row_end", 32'(row_end), 32'(mon_e.re));
        chk("frame_end", 32'(frame_end), 32'(mon_e.fe));
        chk("latency", 32'(cyc), 32'(mon_e.due));
        last_x0 = mon_e.x0;
        last_x1 = mon_e.x1;
      end
    end else begin
      chk("idle_flags", {30'd0, row_end, frame_end}, 32'h0);
      chk("idle_hold", {im11, im21}, {last_x0, last_x1});
    end
    if (reset) begin
      exp_q.delete();
      last_x0 = '0;
      last_x1 = '0;
    end
  end

  initial begin
    logic [DW-1:0] x0, x1, a, d;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_state("reset");

    // Directed values mixed into a counter run with a 3-cycle gap after the third pair.
    drive(1'b1, 16'd120, 16'd40, 16'd100, 16'd140);
    drive(1'b1, 16'd125, 16'hFF6A, 16'd200, 16'd50);
    drive(1'b1, 16'd1, 16'd3, 16'd0, 16'd3);
    repeat (3) idle();
    drive(1'b1, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h7FFF);
    for (int i = 0; i < 5; i++) drive_samples(pick(), pick());
    repeat (3) idle();

    // Reset with two pairs in flight; the second is offered in the reset cycle itself.
    drive_samples(16'h1234, 16'h0F0F);
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b1; dxy_approx = 16'h5555; dxy_detail = 16'h0101;
    idx = 0;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    check_reset_state("midreset");
    repeat (3) idle();

    // Corner-sample combinations back to back, then the random round trip with random gaps.
    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0: x0 = 16'h0000; 1: x0 = 16'h7FFF; 2: x0 = 16'h8000; default: x0 = 16'hFFFF;
      endcase
      case (i / 4)
        0: x1 = 16'h0000; 1: x1 = 16'h7FFF; 2: x1 = 16'h8000; default: x1 = 16'hFFFF;
      endcase
      drive_samples(x0, x1);
    end
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 9) == 0) idle();
      drive_samples(pick(), pick());
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle();
    chk("drain", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
